// File: rtl/dma_desc_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : dma_desc_sequencer
// Brief   : Multi-channel strided descriptor sequencer feeding the read and
//           write descriptor ports of the AXI DMA engines. Each direction
//           round-robins over its pending channels and keeps exactly one
//           descriptor outstanding until the matching status strobe.
// Revision: 1.0 - initial release
// ============================================================================
module dma_desc_sequencer #(
    parameter int NUM_CH     = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 9,
    parameter int CNT_WIDTH  = 16,
    parameter int CH_W       = $clog2(NUM_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [CH_W-1:0]       cfg_ch,
    input  logic                  cfg_dir,
    input  logic [ADDR_WIDTH-1:0] cfg_base,
    input  logic [ADDR_WIDTH-1:0] cfg_stride,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic [CNT_WIDTH-1:0]  cfg_count,
    input  logic [NUM_CH-1:0]     ch_abort,
    output logic [NUM_CH-1:0]     busy,
    output logic [NUM_CH-1:0]     done,
    output logic [1:0]            err_unexp_status,
    output logic [ADDR_WIDTH-1:0] m_axis_read_desc_addr,
    output logic [LEN_WIDTH-1:0]  m_axis_read_desc_len,
    output logic                  m_axis_read_desc_valid,
    input  logic                  m_axis_read_desc_ready,
    input  logic                  s_axis_read_desc_status_valid,
    output logic [ADDR_WIDTH-1:0] m_axis_write_desc_addr,
    output logic [LEN_WIDTH-1:0]  m_axis_write_desc_len,
    output logic                  m_axis_write_desc_valid,
    input  logic                  m_axis_write_desc_ready,
    input  logic                  s_axis_write_desc_status_valid
);

    // Channel states
    localparam logic [1:0] CH_IDLE   = 2'd0;
    localparam logic [1:0] CH_PEND   = 2'd1;
    localparam logic [1:0] CH_ISSUED = 2'd2;

    // Direction FSM states (index 0 = read, 1 = write)
    localparam logic [1:0] D_IDLE = 2'd0;
    localparam logic [1:0] D_REQ  = 2'd1;
    localparam logic [1:0] D_WAIT = 2'd2;

    // Per-channel program and progress
    logic [1:0]            ch_state_q  [NUM_CH];
    logic [ADDR_WIDTH-1:0] cur_addr_q  [NUM_CH];
    logic [ADDR_WIDTH-1:0] stride_q    [NUM_CH];
    logic [LEN_WIDTH-1:0]  len_q       [NUM_CH];
    logic [CNT_WIDTH-1:0]  remaining_q [NUM_CH];
    logic [NUM_CH-1:0]     dir_q;
    logic [NUM_CH-1:0]     abort_q;
    logic [NUM_CH-1:0]     done_q;

    // Per-direction sequencing
    logic [1:0]            dstate_q    [2];
    logic [1:0]            dstate_d    [2];
    logic [CH_W-1:0]       rr_q        [2];
    logic [CH_W-1:0]       gnt_ch_q    [2];
    logic [ADDR_WIDTH-1:0] desc_addr_q [2];
    logic [LEN_WIDTH-1:0]  desc_len_q  [2];
    logic [1:0]            err_q;

    logic [1:0]            w_status;
    logic [1:0]            w_ready;
    logic [1:0]            w_found;
    logic [1:0]            w_grant;
    logic [1:0]            w_ack;
    logic [1:0]            w_cmpl;
    logic [1:0]            w_unexp;
    logic [1:0]            w_desc_valid;
    logic [CH_W-1:0]       w_gnt_ch    [2];
    logic [CH_W-1:0]       w_rr_nxt    [2];
    logic                  w_cfg_fire;

    assign w_status = {s_axis_write_desc_status_valid, s_axis_read_desc_status_valid};
    assign w_ready  = {m_axis_write_desc_ready, m_axis_read_desc_ready};

    // Busy flags and config acceptance for the addressed channel
    always_comb begin
        cfg_ready = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            busy[i] = (ch_state_q[i] != CH_IDLE);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = (ch_state_q[i] == CH_IDLE);
            end
        end
    end

    assign w_cfg_fire = cfg_valid & cfg_ready;

    // Round-robin search: first pending, non-aborting channel at or after rr_q
    always_comb begin
        int idx;
        idx = 0;
        for (int d = 0; d < 2; d++) begin
            w_found[d]  = 1'b0;
            w_gnt_ch[d] = '0;
            for (int k = 0; k < NUM_CH; k++) begin
                idx = (int'(rr_q[d]) + k) % NUM_CH;
                if (!w_found[d] && (ch_state_q[idx] == CH_PEND) &&
                    (dir_q[idx] == d[0]) && !ch_abort[idx]) begin
                    w_found[d]  = 1'b1;
                    w_gnt_ch[d] = CH_W'(idx);
                end
            end
            w_rr_nxt[d] = (w_gnt_ch[d] == CH_W'(NUM_CH - 1)) ? '0 : w_gnt_ch[d] + CH_W'(1);
        end
    end

    // Direction FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dstate_q[0] <= D_IDLE;
            dstate_q[1] <= D_IDLE;
        end else begin
            dstate_q[0] <= dstate_d[0];
            dstate_q[1] <= dstate_d[1];
        end
    end

    // Direction FSM next-state: grant, wait for handshake, wait for status
    always_comb begin
        for (int d = 0; d < 2; d++) begin
            dstate_d[d] = dstate_q[d];
            case (dstate_q[d])
                D_IDLE:  if (w_found[d])  dstate_d[d] = D_REQ;
                D_REQ:   if (w_ready[d])  dstate_d[d] = D_WAIT;
                D_WAIT:  if (w_status[d]) dstate_d[d] = D_IDLE;
                default: dstate_d[d] = D_IDLE;
            endcase
        end
    end

    // Direction FSM outputs: per-cycle control strobes
    always_comb begin
        for (int d = 0; d < 2; d++) begin
            w_grant[d]      = (dstate_q[d] == D_IDLE) & w_found[d];
            w_ack[d]        = (dstate_q[d] == D_REQ)  & w_ready[d];
            w_cmpl[d]       = (dstate_q[d] == D_WAIT) & w_status[d];
            w_unexp[d]      = (dstate_q[d] != D_WAIT) & w_status[d];
            w_desc_valid[d] = (dstate_q[d] == D_REQ);
        end
    end

    // Descriptor output registers, round-robin pointers and sticky errors
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                rr_q[d]        <= '0;
                gnt_ch_q[d]    <= '0;
                desc_addr_q[d] <= '0;
                desc_len_q[d]  <= '0;
            end
            err_q <= '0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (w_grant[d]) begin
                    gnt_ch_q[d]    <= w_gnt_ch[d];
                    rr_q[d]        <= w_rr_nxt[d];
                    desc_addr_q[d] <= cur_addr_q[w_gnt_ch[d]];
                    desc_len_q[d]  <= len_q[w_gnt_ch[d]];
                end
                if (w_unexp[d]) begin
                    err_q[d] <= 1'b1;
                end
            end
        end
    end

    // Channel lifecycle: program, issue, complete, abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ch_state_q[i]  <= CH_IDLE;
                cur_addr_q[i]  <= '0;
                stride_q[i]    <= '0;
                len_q[i]       <= '0;
                remaining_q[i] <= '0;
            end
            dir_q   <= '0;
            abort_q <= '0;
            done_q  <= '0;
        end else begin
            done_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                case (ch_state_q[i])
                    CH_IDLE: begin
                        if (w_cfg_fire && (cfg_ch == CH_W'(i))) begin
                            cur_addr_q[i]  <= cfg_base;
                            stride_q[i]    <= cfg_stride;
                            len_q[i]       <= cfg_len;
                            remaining_q[i] <= cfg_count;
                            dir_q[i]       <= cfg_dir;
                            abort_q[i]     <= 1'b0;
                            // A zero-count program finishes on the spot
                            if (cfg_count == '0) begin
                                done_q[i] <= 1'b1;
                            end else begin
                                ch_state_q[i] <= CH_PEND;
                            end
                        end
                    end
                    CH_PEND: begin
                        if (ch_abort[i]) begin
                            ch_state_q[i] <= CH_IDLE;
                        end else if (w_grant[dir_q[i]] && (w_gnt_ch[dir_q[i]] == CH_W'(i))) begin
                            ch_state_q[i] <= CH_ISSUED;
                        end
                    end
                    CH_ISSUED: begin
                        // Abort is remembered; the in-flight descriptor still completes
                        if (ch_abort[i]) begin
                            abort_q[i] <= 1'b1;
                        end
                        if (w_cmpl[dir_q[i]] && (gnt_ch_q[dir_q[i]] == CH_W'(i))) begin
                            remaining_q[i] <= remaining_q[i] - CNT_WIDTH'(1);
                            cur_addr_q[i]  <= cur_addr_q[i] + stride_q[i];
                            if (abort_q[i] || ch_abort[i]) begin
                                ch_state_q[i] <= CH_IDLE;
                                abort_q[i]    <= 1'b0;
                            end else if (remaining_q[i] == CNT_WIDTH'(1)) begin
                                ch_state_q[i] <= CH_IDLE;
                                done_q[i]     <= 1'b1;
                            end else begin
                                ch_state_q[i] <= CH_PEND;
                            end
                        end
                    end
                    default: ch_state_q[i] <= CH_IDLE;
                endcase
            end
        end
    end

    assign done                    = done_q;
    assign err_unexp_status        = err_q;
    assign m_axis_read_desc_addr   = desc_addr_q[0];
    assign m_axis_read_desc_len    = desc_len_q[0];
    assign m_axis_read_desc_valid  = w_desc_valid[0];
    assign m_axis_write_desc_addr  = desc_addr_q[1];
    assign m_axis_write_desc_len   = desc_len_q[1];
    assign m_axis_write_desc_valid = w_desc_valid[1];

endmodule
`default_nettype wire

// File: tb/tb_dma_desc_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_dma_desc_sequencer
// Brief   : Self-checking bench for dma_desc_sequencer. A transaction-level
//           model of channels and outstanding descriptors predicts every
//           output each cycle; directed tests pin the model with literals.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dma_desc_sequencer;

    localparam int NUM_CH = 4;
    localparam int AW     = 32;
    localparam int LW     = 9;
    localparam int CW     = 16;
    localparam int CH_W   = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic              cfg_dir = 1'b0;
    logic [AW-1:0]     cfg_base = '0;
    logic [AW-1:0]     cfg_stride = '0;
    logic [LW-1:0]     cfg_len = '0;
    logic [CW-1:0]     cfg_count = '0;
    logic [NUM_CH-1:0] ch_abort = '0;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] done;
    logic [1:0]        err_unexp_status;
    logic [AW-1:0]     rd_addr, wr_addr;
    logic [LW-1:0]     rd_len, wr_len;
    logic              rd_valid, wr_valid;
    logic              rd_ready = 1'b1, wr_ready = 1'b1;
    logic              rd_status = 1'b0, wr_status = 1'b0;

    always #5 clk = ~clk;

    dma_desc_sequencer #(
        .NUM_CH(NUM_CH), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_dir(cfg_dir), .cfg_base(cfg_base), .cfg_stride(cfg_stride),
        .cfg_len(cfg_len), .cfg_count(cfg_count), .ch_abort(ch_abort),
        .busy(busy), .done(done), .err_unexp_status(err_unexp_status),
        .m_axis_read_desc_addr(rd_addr), .m_axis_read_desc_len(rd_len),
        .m_axis_read_desc_valid(rd_valid), .m_axis_read_desc_ready(rd_ready),
        .s_axis_read_desc_status_valid(rd_status),
        .m_axis_write_desc_addr(wr_addr), .m_axis_write_desc_len(wr_len),
        .m_axis_write_desc_valid(wr_valid), .m_axis_write_desc_ready(wr_ready),
        .s_axis_write_desc_status_valid(wr_status)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: channel records plus "which channel has a
    // descriptor out" per direction. Evaluated at the falling edge, when
    // all inputs for the coming rising edge are stable.
    // ------------------------------------------------------------------
    int          m_st   [NUM_CH];   // 0 idle, 1 waiting for a grant, 2 descriptor out
    logic [31:0] m_addr [NUM_CH];
    logic [31:0] m_strd [NUM_CH];
    int          m_len  [NUM_CH];
    int          m_rem  [NUM_CH];
    int          m_dir  [NUM_CH];
    bit          m_abt  [NUM_CH];
    int          m_out  [2];
    bit          m_ack  [2];
    int          m_rr   [2];
    logic [3:0]  m_done;
    logic [1:0]  m_err;
    logic [31:0] rd_log[$];
    logic [31:0] wr_log[$];

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_st[i] = 0; m_addr[i] = 0; m_strd[i] = 0; m_len[i] = 0;
            m_rem[i] = 0; m_dir[i] = 0; m_abt[i] = 0;
        end
        for (int d = 0; d < 2; d++) begin
            m_out[d] = -1; m_ack[d] = 0; m_rr[d] = 0;
        end
        m_done = '0;
        m_err  = '0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                model_reset();
            end else begin
                logic [3:0] exp_busy;
                logic [3:0] new_done;
                bit         busy_pre [NUM_CH];
                logic [1:0] stat, rdy;
                bit         waiting;
                stat = {wr_status, rd_status};
                rdy  = {wr_ready, rd_ready};
                for (int i = 0; i < NUM_CH; i++) begin
                    busy_pre[i] = (m_st[i] != 0);
                    exp_busy[i] = busy_pre[i];
                end
                // compare this cycle's outputs
                chk("busy", busy, exp_busy);
                chk("done", done, m_done);
                chk("err_unexp_status", err_unexp_status, m_err);
                chk("cfg_ready", cfg_ready, !busy_pre[cfg_ch]);
                for (int d = 0; d < 2; d++) begin
                    bit ev;
                    ev = (m_out[d] >= 0) && !m_ack[d];
                    chk(d ? "wr_valid" : "rd_valid", d ? wr_valid : rd_valid, ev);
                    if (ev) begin
                        chk(d ? "wr_addr" : "rd_addr", d ? wr_addr : rd_addr, m_addr[m_out[d]]);
                        chk(d ? "wr_len" : "rd_len", d ? wr_len : rd_len, m_len[m_out[d]]);
                    end
                end
                // advance to the next cycle
                new_done = '0;
                for (int d = 0; d < 2; d++) begin
                    waiting = (m_out[d] >= 0) && m_ack[d];
                    if (stat[d] && !waiting) m_err[d] = 1'b1;
                    if (m_out[d] < 0) begin
                        bit found;
                        found = 0;
                        for (int k = 0; k < NUM_CH; k++) begin
                            int c;
                            c = (m_rr[d] + k) % NUM_CH;
                            if (!found && m_st[c] == 1 && m_dir[c] == d && !ch_abort[c]) begin
                                found = 1;
                                m_out[d] = c; m_ack[d] = 0; m_st[c] = 2;
                                m_rr[d] = (c + 1) % NUM_CH;
                            end
                        end
                    end else if (!m_ack[d]) begin
                        if (rdy[d]) begin
                            m_ack[d] = 1;
                            if (d == 0) rd_log.push_back(m_addr[m_out[d]]);
                            else        wr_log.push_back(m_addr[m_out[d]]);
                        end
                    end else if (stat[d]) begin
                        int c;
                        c = m_out[d];
                        m_rem[c]  = m_rem[c] - 1;
                        m_addr[c] = m_addr[c] + m_strd[c];
                        if (m_abt[c] || ch_abort[c]) begin
                            m_st[c] = 0; m_abt[c] = 0;
                        end else if (m_rem[c] == 0) begin
                            m_st[c] = 0; new_done[c] = 1'b1;
                        end else begin
                            m_st[c] = 1;
                        end
                        m_out[d] = -1;
                    end
                end
                for (int i = 0; i < NUM_CH; i++) begin
                    if (ch_abort[i] && m_st[i] == 1) m_st[i] = 0;
                    else if (ch_abort[i] && m_st[i] == 2) m_abt[i] = 1;
                end
                if (cfg_valid && !busy_pre[cfg_ch]) begin
                    m_addr[cfg_ch] = cfg_base; m_strd[cfg_ch] = cfg_stride;
                    m_len[cfg_ch]  = int'(cfg_len); m_rem[cfg_ch] = int'(cfg_count);
                    m_dir[cfg_ch]  = int'(cfg_dir); m_abt[cfg_ch] = 0;
                    if (cfg_count == 0) new_done[cfg_ch] = 1'b1;
                    else                m_st[cfg_ch] = 1;
                end
                m_done = new_done;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int ch, input bit dir, input logic [31:0] base,
                       input logic [31:0] stride, input int len, input int count);
        cfg_valid  = 1'b1;
        cfg_ch     = CH_W'(ch);
        cfg_dir    = dir;
        cfg_base   = base;
        cfg_stride = stride;
        cfg_len    = LW'(len);
        cfg_count  = CW'(count);
        tick();
        cfg_valid  = 1'b0;
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual timeout required descriptor", name);
    endtask

    // Answer n descriptors on one direction: handshake, then status after lat cycles
    task automatic serve(input int d, input int n, input int lat);
        for (int k = 0; k < n; k++) begin
            int t;
            t = 0;
            while (!(d ? wr_valid : rd_valid)) begin
                if (t >= 200) begin
                    timeout("serve_wait");
                    return;
                end
                tick();
                t++;
            end
            tick();
            repeat (lat) tick();
            if (d == 0) rd_status = 1'b1; else wr_status = 1'b1;
            tick();
            rd_status = 1'b0;
            wr_status = 1'b0;
        end
    endtask

    // Handshake both directions together so their status strobes coincide
    task automatic serve_pair(input int n, input int lat);
        for (int k = 0; k < n; k++) begin
            int t;
            t = 0;
            while (!(rd_valid && wr_valid)) begin
                if (t >= 200) begin
                    timeout("serve_pair_wait");
                    return;
                end
                tick();
                t++;
            end
            rd_ready = 1'b1; wr_ready = 1'b1;
            tick();
            rd_ready = 1'b0; wr_ready = 1'b0;
            repeat (lat) tick();
            rd_status = 1'b1; wr_status = 1'b1;
            tick();
            rd_status = 1'b0; wr_status = 1'b0;
        end
    endtask

    task automatic wait_rd_valid();
        int t;
        t = 0;
        while (!rd_valid) begin
            if (t >= 200) begin
                timeout("rd_valid_wait");
                return;
            end
            tick();
            t++;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] exp_order [6];

    initial begin
        // reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_unexp_status, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_rd_addr", rd_addr, 0);
        rst_n = 1'b1;
        tick();

        // single channel strided read
        rd_log.delete(); wr_log.delete();
        cfg(0, 0, 32'h8, 32'h50, 80, 3);
        serve(0, 3, 4);
        chk("t1_done", done, 4'b0001);
        chk("t1_count", rd_log.size(), 3);
        chk("t1_addr0", rd_log[0], 32'h8);
        chk("t1_addr1", rd_log[1], 32'h58);
        chk("t1_addr2", rd_log[2], 32'hA8);
        repeat (2) tick();

        // three read channels round-robin
        rd_log.delete(); wr_log.delete();
        fork
            begin
                cfg(0, 0, 32'h1000, 32'h10, 16, 2);
                cfg(1, 0, 32'h2000, 32'h10, 17, 2);
                cfg(2, 0, 32'h3000, 32'h10, 18, 2);
            end
            serve(0, 6, 2);
        join
        exp_order = '{32'h1000, 32'h2000, 32'h3000, 32'h1010, 32'h2010, 32'h3010};
        chk("t2_count", rd_log.size(), 6);
        for (int k = 0; k < 6; k++) chk("t2_order", rd_log[k], exp_order[k]);
        chk("t2_no_write", wr_log.size(), 0);
        repeat (2) tick();

        // concurrent read and write with coincident status
        rd_log.delete(); wr_log.delete();
        rd_ready = 1'b0; wr_ready = 1'b0;
        cfg(3, 0, 32'h100, 32'h40, 16, 2);
        cfg(1, 1, 32'h4, 32'h8, 32, 2);
        serve_pair(2, 3);
        chk("t3_done_pair", done, 4'b1010);
        chk("t3_rd1", rd_log[1], 32'h140);
        chk("t3_wr1", wr_log[1], 32'hC);
        rd_ready = 1'b1; wr_ready = 1'b1;
        repeat (2) tick();

        // stalled handshake with a stray status strobe
        rd_log.delete();
        rd_ready = 1'b0;
        cfg(0, 0, 32'h500, 32'h0, 7, 1);
        wait_rd_valid();
        for (int s = 0; s < 7; s++) begin
            rd_status = (s == 3);
            tick();
        end
        rd_status = 1'b0;
        chk("t4_err", err_unexp_status, 2'b01);
        chk("t4_still_valid", rd_valid, 1);
        rd_ready = 1'b1;
        tick();
        repeat (2) tick();
        rd_status = 1'b1;
        tick();
        rd_status = 1'b0;
        chk("t4_done", done, 4'b0001);
        repeat (2) tick();

        // address wrap, then zero-count program
        rd_log.delete(); wr_log.delete();
        cfg(0, 0, 32'hFFFF_FFF0, 32'h20, 5, 2);
        serve(0, 2, 3);
        chk("t5_addr0", rd_log[0], 32'hFFFF_FFF0);
        chk("t5_wrap", rd_log[1], 32'h0000_0010);
        cfg(1, 1, 32'h77, 32'h1, 3, 0);
        chk("t5_zero_done", done, 4'b0010);
        chk("t5_zero_busy", busy[1], 0);
        repeat (5) tick();
        chk("t5_zero_noissue", wr_log.size(), 0);

        // busy-channel program rejected, abort while issued
        rd_log.delete();
        cfg(2, 0, 32'h300, 32'h4, 12, 4);
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_dir = 1'b1;
        cfg_base = 32'hDEAD0; cfg_count = 16'd1;
        #1;
        chk("t6_cfg_ready_busy", cfg_ready, 0);
        tick();
        cfg_valid = 1'b0;
        wait_rd_valid();
        tick();
        tick();
        ch_abort = 4'b0100;
        tick();
        ch_abort = 4'b0000;
        tick();
        rd_status = 1'b1;
        tick();
        rd_status = 1'b0;
        repeat (10) tick();
        chk("t6_busy2", busy[2], 0);
        chk("t6_one_issue", rd_log.size(), 1);
        chk("t6_addr", rd_log[0], 32'h300);

        // asynchronous reset while a descriptor waits for ready
        rd_ready = 1'b0;
        cfg(0, 0, 32'h40, 32'h4, 8, 1);
        wait_rd_valid();
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk("t7_valid", rd_valid, 0);
        chk("t7_busy", busy, 0);
        chk("t7_err", err_unexp_status, 0);
        chk("t7_cfg_ready", cfg_ready, 1);
        chk("t7_addr", rd_addr, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        rd_ready = 1'b1;
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
